// File: rtl/buzzer_seq.sv
// Buzzer tone/cadence sequencer: plays REPS bursts of a table-selected square wave
// separated by silent gaps, with busy/done handshake and abort.
module buzzer_seq #(
   parameter int unsigned CLK_HZ  = 100000000,
   parameter int unsigned N_TONES = 4,
   parameter int unsigned HP_W    = 20,
   parameter logic [N_TONES*HP_W-1:0] TONE_HALF =
      {20'd265000, 20'd165000, 20'd65000, 20'd35000},
   parameter int unsigned MS_W    = 10,
   parameter int unsigned REP_W   = 4,
   parameter int unsigned SEL_W   = (N_TONES > 1) ? $clog2(N_TONES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [SEL_W-1:0] tone_sel,
   input  logic [MS_W-1:0]  on_ms,
   input  logic [MS_W-1:0]  off_ms,
   input  logic [REP_W-1:0] reps,
   output logic             busy,
   output logic             done,
   output logic             buzzer_out
);

   localparam int unsigned MS_DIV = CLK_HZ / 1000;
   localparam int unsigned PS_W   = $clog2(MS_DIV + 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(MS_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

   state_t             state_q, state_d;
   logic [PS_W-1:0]    pre_q, pre_d;
   logic [MS_W-1:0]    ms_q, ms_d;
   logic [HP_W-1:0]    tcnt_q, tcnt_d;
   logic               buz_q, buz_d;
   logic               done_q, done_d;
   logic [HP_W-1:0]    half_q, half_d;
   logic [MS_W-1:0]    on_q, on_d;
   logic [MS_W-1:0]    off_q, off_d;
   logic [REP_W-1:0]   reps_q, reps_d;

   logic [HP_W-1:0]    sel_half;
   logic               sel_ok;
   logic               ms_tick;
   logic               restart;

   always_comb begin
      sel_half = '0;
      for (int unsigned i = 0; i < N_TONES; i++) begin
         if (32'(tone_sel) == i) sel_half = TONE_HALF[i*HP_W +: HP_W];
      end
      sel_ok = (32'(tone_sel) < N_TONES);
   end

   assign ms_tick = (pre_q == PS_LAST);

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      ms_d    = ms_q;
      tcnt_d  = tcnt_q;
      buz_d   = buz_q;
      done_d  = 1'b0;
      half_d  = half_q;
      on_d    = on_q;
      off_d   = off_q;
      reps_d  = reps_q;
      restart = 1'b0;

      if (state_q != S_IDLE) begin
         if (ms_tick) begin
            pre_d = '0;
            ms_d  = ms_q + MS_W'(1);
         end else begin
            pre_d = pre_q + PS_W'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start && (reps != '0) && sel_ok) begin
               state_d = S_ON;
               restart = 1'b1;
               half_d  = sel_half;
               on_d    = (on_ms == '0) ? MS_W'(1) : on_ms;
               off_d   = off_ms;
               reps_d  = reps;
            end
         end
         S_ON: begin
            if (tcnt_q == half_q - HP_W'(1)) begin
               tcnt_d = '0;
               buz_d  = ~buz_q;
            end else begin
               tcnt_d = tcnt_q + HP_W'(1);
            end
            if (stop) begin
               state_d = S_IDLE;
               restart = 1'b1;
            end else if (ms_tick && (ms_q == on_q - MS_W'(1))) begin
               restart = 1'b1;
               if (reps_q == REP_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  reps_d  = reps_q - REP_W'(1);
                  state_d = (off_q == '0) ? S_ON : S_OFF;
               end
            end
         end
         S_OFF: begin
            if (stop) begin
               state_d = S_IDLE;
               restart = 1'b1;
            end else if (ms_tick && (ms_q == off_q - MS_W'(1))) begin
               state_d = S_ON;
               restart = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            restart = 1'b1;
         end
      endcase

      // Every state entry (including ON re-entry) starts timing and tone phase from zero.
      if (restart) begin
         pre_d  = '0;
         ms_d   = '0;
         tcnt_d = '0;
         buz_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         ms_q    <= '0;
         tcnt_q  <= '0;
         buz_q   <= 1'b0;
         done_q  <= 1'b0;
         half_q  <= '0;
         on_q    <= '0;
         off_q   <= '0;
         reps_q  <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         ms_q    <= ms_d;
         tcnt_q  <= tcnt_d;
         buz_q   <= buz_d;
         done_q  <= done_d;
         half_q  <= half_d;
         on_q    <= on_d;
         off_q   <= off_d;
         reps_q  <= reps_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign buzzer_out = buz_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// Self-checking bench for buzzer_seq: arithmetic pattern model checked every cycle,
// plus directed scenarios with hand-computed lengths and edge counts.
module tb_buzzer_seq;

   localparam int D = 10;

   logic       clk, rst, start, stop, start2;
   logic [1:0] tone_sel, tone_sel2;
   logic [9:0] on_ms, off_ms;
   logic [3:0] reps;
   logic       busy, done, buz, busy2, done2, buz2;

   int n_tests = 0;
   int n_fail  = 0;

   buzzer_seq #(
      .CLK_HZ(10000), .N_TONES(4), .HP_W(20),
      .TONE_HALF({20'd8, 20'd5, 20'd3, 20'd2}), .MS_W(10), .REP_W(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .tone_sel(tone_sel),
      .on_ms(on_ms), .off_ms(off_ms), .reps(reps),
      .busy(busy), .done(done), .buzzer_out(buz)
   );

   buzzer_seq #(
      .CLK_HZ(10000), .N_TONES(3), .HP_W(20),
      .TONE_HALF({20'd5, 20'd3, 20'd2}), .MS_W(10), .REP_W(4)
   ) dut3 (
      .clk(clk), .rst(rst), .start(start2), .stop(stop), .tone_sel(tone_sel2),
      .on_ms(on_ms), .off_ms(off_ms), .reps(reps),
      .busy(busy2), .done(done2), .buzzer_out(buz2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time index t from busy rise; pattern is periodic in (on+off)*D.
   int m_active = 0, m_t = 0, m_half = 1, m_on = 1, m_off = 0, m_reps = 1;

   function automatic int half_of(input int s);
      case (s)
         0: return 2;
         1: return 3;
         2: return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int m_total();
      return m_reps * m_on * D + (m_reps - 1) * m_off * D;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 0;
      end else if (!m_active || m_t == m_total()) begin
         m_active = 0;
         if (start && reps != 0) begin
            m_half   = half_of(int'(tone_sel));
            m_on     = (on_ms == 0) ? 1 : int'(on_ms);
            m_off    = int'(off_ms);
            m_reps   = int'(reps);
            m_t      = 0;
            m_active = 1;
         end
      end else if (stop) begin
         m_active = 0;
      end else begin
         m_t++;
      end
   end

   always @(negedge clk) begin
      int eb, ed, ez, ph;
      eb = 0; ed = 0; ez = 0;
      if (m_active) begin
         if (m_t == m_total()) ed = 1;
         else begin
            eb = 1;
            ph = m_t % ((m_on + m_off) * D);
            if (ph < m_on * D) ez = (ph / m_half) % 2;
         end
      end
      chk("model_busy", busy, eb);
      chk("model_done", done, ed);
      chk("model_buzzer", buz, ez);
   end

   task automatic run(input string nm, input int sel, input int on, input int off,
                      input int rp, input int stop_at, input int restart_at,
                      input int exp_len, input int exp_rises);
      int n, rises, prev, len, lim;
      @(negedge clk);
      tone_sel = 2'(sel); on_ms = 10'(on); off_ms = 10'(off); reps = 4'(rp);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_busy_rise"}, busy, 1);
      n = 0; rises = 0; prev = 0; len = -1;
      lim = (exp_len < 0) ? 80 : exp_len + 10;
      for (int i = 0; i < lim; i++) begin
         if (done) begin
            len = n;
            break;
         end
         if (stop_at >= 0 && i == stop_at + 1) begin
            chk({nm, "_stop_busy"}, busy, 0);
            chk({nm, "_stop_buz"}, buz, 0);
         end
         if (busy) n++;
         if (buz && !prev) rises++;
         prev = buz;
         start = (i == restart_at);
         if (i == restart_at) begin
            tone_sel = 2'(sel + 1); on_ms = 10'd5; off_ms = 10'd0; reps = 4'd1;
         end
         stop = (i == stop_at);
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
      chk({nm, "_len"}, len, exp_len);
      chk({nm, "_rises"}, rises, exp_rises);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0;
      tone_sel = '0; tone_sel2 = '0; on_ms = '0; off_ms = '0; reps = '0;

      // 1: reset held with random inputs
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_buz", buz, 0);
         chk("rst_busy3", busy2, 0);
         start = 1'($urandom); stop = 1'($urandom); start2 = 1'($urandom);
         tone_sel = 2'($urandom); tone_sel2 = 2'($urandom);
         on_ms = 10'($urandom_range(0, 3)); off_ms = 10'($urandom_range(0, 3));
         reps = 4'($urandom);
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0; start2 = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 2: basic pattern: 20 on + 10 off + 20 on
      run("basic", 2, 2, 1, 2, -1, -1, 50, 4);

      // 3a: zero on/off fields, three back-to-back 10-cycle bursts of period 4
      run("zero", 0, 0, 0, 3, -1, -1, 30, 6);

      // 3b: reps==0 ignored
      @(negedge clk);
      tone_sel = 2'd1; on_ms = 10'd1; off_ms = 10'd1; reps = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("reps0_busy", busy, 0);
         @(negedge clk);
      end

      // 4: abort at cycle 15 of a tone-3 pattern
      run("abort", 3, 2, 1, 4, 15, -1, -1, 1);

      // 5a: start while busy is ignored
      run("restart", 2, 2, 1, 2, -1, 10, 50, 4);

      // 5b: out-of-range select on a 3-tone instance
      @(negedge clk);
      tone_sel2 = 2'd3; on_ms = 10'd1; off_ms = 10'd0; reps = 4'd2; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("sel3_busy", busy2, 0);
      @(negedge clk);
      chk("sel3_busy_b", busy2, 0);
      tone_sel2 = 2'd2; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("sel2_busy", busy2, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("sel2_stop_busy", busy2, 0);
      chk("sel2_stop_done", done2, 0);

      // 6: asynchronous reset mid-burst, then a clean rerun
      @(negedge clk);
      tone_sel = 2'd2; on_ms = 10'd2; off_ms = 10'd1; reps = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_buz", buz, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_buz", buz, 0);
      chk("arst_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run("rerun", 2, 2, 1, 2, -1, -1, 50, 4);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
